// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial byte transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_BIT_DIV = 10;
    localparam int unsigned DEFAULT_TIMEOUT = 1000;
    localparam int unsigned FIFO_DEPTH      = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_tick.sv
// Bit-period tick counter: one-cycle tick every BIT_DIV enabled cycles.
module bit_tick_gen
    import serial_tx_pkg::*;
#(
    parameter int unsigned BIT_DIV = DEFAULT_BIT_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= 8'd0;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Byte-to-serial transmitter with downstream completion handshake and timeout.
// Define SERIAL_TX_BUF_EN to place a 4-entry input FIFO ahead of the shift register.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned BIT_DIV = DEFAULT_BIT_DIV,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       tx_valid_in,
    output logic       tx_ready_out,
    output logic       data_out,
    output logic       write_out,
    input  logic       status_in,
    output logic       busy_out,
    output logic       error_out
);

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] tout_cnt;
    logic [16:0] tout_next;
    logic        data_q;
    logic        busy_q;
    logic        error_q;
    logic        run_q;
    logic        start;
    logic [7:0]  start_byte;
    logic        tick;
    logic        shift_en;

`ifdef SERIAL_TX_BUF_EN
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;

    assign fifo_full    = (fifo_cnt == 3'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_cnt == 3'd0);
    assign tx_ready_out = run_q && !fifo_full;
    assign push         = tx_valid_in && tx_ready_out;
    // Pop only from a non-empty FIFO, so a push into an empty FIFO never bypasses it.
    assign start        = (state == IDLE) && run_q && !fifo_empty && !status_in;
    assign start_byte   = fifo_mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_mem <= '{default: 8'h00};
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= tx_data_in;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (start) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(start);
        end
    end
`else
    // run_q holds ready low while reset is asserted and until the first clock after it.
    assign tx_ready_out = run_q && (state == IDLE) && !status_in;
    assign start        = tx_valid_in && tx_ready_out;
    assign start_byte   = tx_data_in;
`endif

    assign shift_en = (state == SHIFT);

    bit_tick_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .enable (shift_en),
        .tick   (tick)
    );

    assign tout_next = {1'b0, tout_cnt} + 17'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            bit_cnt  <= 3'd0;
            tout_cnt <= 16'd0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            error_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= start_byte;
                        bit_cnt <= 3'd0;
                        data_q  <= start_byte[7];
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state    <= WAIT_DONE;
                            tout_cnt <= 16'd0;
                            data_q   <= 1'b0;
                        end else begin
                            data_q <= shreg[6];
                        end
                    end
                end
                WAIT_DONE: begin
                    // The first WAIT_DONE cycle never completes: the counter must be >= 1.
                    if (!status_in && (tout_cnt != 16'd0)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (status_in && (tout_next >= TIMEOUT_W)) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        tout_cnt <= sat_inc16(tout_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign write_out = tick;
    assign busy_out  = busy_q;
    assign error_out = error_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table vectors, hand sequences and random bytes.
module tb_serial_tx;

    localparam int BD = 10;
    localparam int TO = 50;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data_in;
    logic       tx_valid_in;
    logic       tx_ready_out;
    logic       data_out;
    logic       write_out;
    logic       status_in;
    logic       busy_out;
    logic       error_out;

    int tests;
    int fails;

    serial_tx #(
        .BIT_DIV (BD),
        .TIMEOUT (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_data_in   (tx_data_in),
        .tx_valid_in  (tx_valid_in),
        .tx_ready_out (tx_ready_out),
        .data_out     (data_out),
        .write_out    (write_out),
        .status_in    (status_in),
        .busy_out     (busy_out),
        .error_out    (error_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        int         hold;      // WAIT_DONE cycles with status_in=1
        bit         noise;     // random status_in during SHIFT
        bit         exp_err;
        int         exp_off;   // cycles after 8th strobe until busy_out=0
    } vec_t;

`ifdef SERIAL_TX_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Spec-level model of the completion handshake.
    function automatic void ref_wait(input int hold, output bit err, output int off);
        if (hold >= TO) begin
            err = 1'b1;
            off = TO + 1;
        end else begin
            err = 1'b0;
            off = ((hold < 1) ? 1 : hold) + 2;
        end
    endfunction

    // Offer a byte and return just after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        tx_valid_in = 1'b1;
        tx_data_in  = b;
        forever begin
            @(negedge clock);
            if (tx_ready_out) break;
            n++;
            if (n > 500) begin
                check("accept_timeout", 32'(n), 32'd0);
                finish_now();
            end
        end
        @(posedge clock);
        #1;
        tx_valid_in = 1'b0;
        tx_data_in  = 8'($urandom);
    endtask

    task automatic check_tx(input logic [7:0] b, input int hold, input bit noise,
                            input bit exp_err, input int exp_off);
        int         bad;
        int         nstrobe;
        logic [7:0] got;
        logic       exp_d;
        logic       exp_w;
        logic       exp_r;
        bad     = 0;
        nstrobe = 0;
        got     = 8'h00;
        if (BUF) begin
            status_in = 1'b0;
            @(negedge clock);
            if (busy_out !== 1'b0) bad++;
            @(posedge clock);
            #1;
        end
        for (int t = 1; t <= 8 * BD; t++) begin
            status_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
            exp_w = ((t % BD) == 0);
            exp_d = b[7 - (t - 1) / BD];
            if (write_out !== exp_w || data_out !== exp_d || busy_out !== 1'b1 ||
                error_out !== 1'b0 || tx_ready_out !== BUF) bad++;
            if (write_out === 1'b1) begin
                got = {got[6:0], data_out};
                nstrobe++;
            end
            @(posedge clock);
            #1;
        end
        check("shift_cycles", 32'(bad), 32'd0);
        check("serial_byte", 32'(got), 32'(b));
        check("strobe_count", 32'(nstrobe), 32'd8);
        bad = 0;
        for (int off = 1; off <= exp_off + 1; off++) begin
            status_in = ((off - 1) < hold) ? 1'b1 : 1'b0;
            @(negedge clock);
            if (write_out !== 1'b0 || data_out !== 1'b0) bad++;
            if (off < exp_off) begin
                if (busy_out !== 1'b1 || error_out !== 1'b0 || tx_ready_out !== BUF) bad++;
            end else if (off == exp_off) begin
                exp_r = BUF ? 1'b1 : !status_in;
                check("idle_busy", 32'(busy_out), 32'd0);
                check("error_pulse", 32'(error_out), 32'(exp_err));
                check("ready_back", 32'(tx_ready_out), 32'(exp_r));
            end else begin
                check("error_clear", 32'(error_out), 32'd0);
            end
            @(posedge clock);
            #1;
        end
        check("wait_cycles", 32'(bad), 32'd0);
        status_in = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [7:0] rb;
        int         rh;
        bit         rn;
        bit         rerr;
        int         roff;
        int         cnt;
        logic [7:0] acc;

        vecs[0] = '{8'hA5, 0,   1'b0, 1'b0, 3};
        vecs[1] = '{8'hA5, 30,  1'b0, 1'b0, 32};
        vecs[2] = '{8'h3C, 1,   1'b1, 1'b0, 3};
        vecs[3] = '{8'hFF, 49,  1'b0, 1'b0, 51};
        vecs[4] = '{8'h81, 50,  1'b0, 1'b1, 51};
        vecs[5] = '{8'h00, 200, 1'b1, 1'b1, 51};
        vecs[6] = '{8'h7E, 2,   1'b1, 1'b0, 4};

        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        tx_valid_in = 1'b0;
        tx_data_in  = 8'h00;
        status_in   = 1'b0;
        #1;
        check("reset_state", 32'({tx_ready_out, data_out, write_out, busy_out, error_out}),
              32'd0);
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready_idle", 32'({tx_ready_out, busy_out}), 32'b10);

        foreach (vecs[i]) begin
            send(vecs[i].data);
            check_tx(vecs[i].data, vecs[i].hold, vecs[i].noise, vecs[i].exp_err,
                     vecs[i].exp_off);
        end

        // Reset in the third bit aborts the byte.
        send(8'hE7);
        repeat (2 * BD + 3) @(posedge clock);
        #1;
        check("third_bit_data", 32'({busy_out, data_out}), 32'b11);
        reset = 1'b1;
        #1;
        check("reset_outputs", 32'({tx_ready_out, data_out, write_out, busy_out, error_out}),
              32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clock);
            cnt += int'(write_out) + int'(busy_out) + int'(tx_ready_out);
        end
        check("reset_quiet", 32'(cnt), 32'd0);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready_after_reset", 32'(tx_ready_out), 32'd1);
        cnt = 0;
        repeat (2 * BD) begin
            @(negedge clock);
            cnt += int'(write_out) + int'(busy_out);
        end
        check("no_strobe_after_reset", 32'(cnt), 32'd0);
        @(posedge clock);
        #1;
        send(8'h3C);
        check_tx(8'h3C, 0, 1'b0, 1'b0, 3);

`ifdef SERIAL_TX_BUF_EN
        begin
            logic [7:0] got_q[$];
            logic       rd;
            int         nb;
            status_in = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                tx_valid_in = 1'b1;
                tx_data_in  = 8'(i);
                @(negedge clock);
                check("push_ready", 32'(tx_ready_out), 32'd1);
                @(posedge clock);
                #1;
            end
            tx_data_in = 8'h05;
            @(negedge clock);
            check("fifo_full_stall", 32'(tx_ready_out), 32'd0);
            @(posedge clock);
            #1;
            status_in = 1'b0;
            nb        = 0;
            acc       = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clock);
                rd = tx_ready_out;
                if (write_out === 1'b1) begin
                    acc = {acc[6:0], data_out};
                    nb++;
                    if ((nb % 8) == 0) got_q.push_back(acc);
                end
                if (nb == 40) break;
                @(posedge clock);
                #1;
                if (rd && tx_valid_in) tx_valid_in = 1'b0;
            end
            check("fifo_byte_count", 32'(got_q.size()), 32'd5);
            for (int i = 0; i < got_q.size(); i++) begin
                check("fifo_order", 32'(got_q[i]), 32'(i + 1));
            end
            repeat (2 * BD) @(posedge clock);
            #1;
        end
`else
        // A byte offered during SHIFT waits for IDLE and is sent exactly once.
        status_in   = 1'b0;
        send(8'h96);
        tx_valid_in = 1'b1;
        tx_data_in  = 8'h4B;
        cnt         = 0;
        acc         = 8'h00;
        forever begin
            @(negedge clock);
            if (tx_ready_out) break;
            if (write_out === 1'b1) acc = {acc[6:0], data_out};
            cnt++;
            if (cnt > 500) begin
                check("holdoff_timeout", 32'(cnt), 32'd0);
                finish_now();
            end
        end
        check("hold_off_cycles", 32'(cnt), 32'(8 * BD + 2));
        check("first_byte", 32'(acc), 32'h96);
        @(posedge clock);
        #1;
        tx_valid_in = 1'b0;
        check_tx(8'h4B, 0, 1'b0, 1'b0, 3);
        cnt = 0;
        repeat (3 * BD) begin
            @(negedge clock);
            cnt += int'(write_out) + int'(busy_out);
        end
        check("no_duplicate", 32'(cnt), 32'd0);
        @(posedge clock);
        #1;
`endif

        for (int r = 0; r < 8; r++) begin
            rb = 8'($urandom);
            rh = $urandom_range(0, TO + 5);
            rn = 1'($urandom_range(0, 1));
            ref_wait(rh, rerr, roff);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            send(rb);
            check_tx(rb, rh, rn, rerr, roff);
        end

        finish_now();
    end

endmodule
